// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: op codes, FSM states and the
// buffered command record.
package alu_seq_pkg;

    localparam logic [2:0] OP_NEGA = 3'b000;
    localparam logic [2:0] OP_NEGB = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] tag;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command buffer: DEPTH-entry synchronous FIFO with an extra pointer wrap bit
// to tell full from empty. Pushes when full and pops when empty are ignored.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  cmd_t wdata,
    output cmd_t rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    cmd_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is data only; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Front end for the combinational 4-bit ALU: buffers commands, drives the ALU
// from registers, waits a fixed settle time, then holds the tagged result.
// Both ports use valid/ready: a transfer happens on a rising edge where valid
// and ready are both high; valid never depends on ready.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_s,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic       out_zero,
    output logic [2:0] out_op,
    output logic [1:0] out_tag,
    output state_t     state
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    cmd_t          wdata;
    cmd_t          head;
    logic [1:0]    tag_cnt;
    logic [1:0]    cur_tag;
    logic [CW-1:0] cnt;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign wdata    = '{op: in_op, a: in_a, b: in_b, tag: tag_cnt};
    // A pop always coincides with issuing that command onto the ALU buses.
    assign pop      = !empty && ((state == IDLE) || ((state == HOLD) && out_ready));

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt <= '0;
        end else if (push) begin
            tag_cnt <= tag_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_tag    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_op     <= '0;
            out_tag    <= '0;
        end else begin
            if (pop) begin
                alu_a   <= head.a;
                alu_b   <= head.b;
                alu_op  <= head.op;
                cur_tag <= head.tag;
                cnt     <= CNT_INIT;
            end
            case (state)
                IDLE: begin
                    if (pop) state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        out_result <= alu_s;
                        out_zero   <= (alu_s == 4'd0);
                        out_op     <= alu_op;
                        out_tag    <= cur_tag;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= pop ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed scenarios plus random
// traffic, scored against an arithmetic reference model and expected queue.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_s;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_result;
    logic       out_zero;
    logic [2:0] out_op;
    logic [1:0] out_tag;
    state_t     state;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard entries are {tag, op, result, zero}.
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int         model_tag = 0;
    int         cyc = 0;
    int         last_out_cyc = -1;
    bit         stream_mode = 1'b0;
    bit         held_valid = 1'b0;
    logic [9:0] held = '0;
    bit         rand_done = 1'b0;
    int         sweep_res[8] = '{13, 11, 8, 14, 1, 7, 15, 6};

    alu_cmd_sequencer #(.DEPTH(4), .SETTLE_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_s      (alu_s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_op     (out_op),
        .out_tag    (out_tag),
        .state      (state)
    );

    // Reference ALU behaviour in plain integer arithmetic, reduced mod 16.
    function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        int x;
        int y;
        int r;
        x = int'(a);
        y = int'(b);
        case (op)
            OP_NEGA: r = 0 - x;
            OP_NEGB: r = 0 - y;
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_MUL:  r = x * y;
            default: r = x ^ y;
        endcase
        return 4'(r & 15);
    endfunction

    assign alu_s = ref_alu(alu_op, alu_a, alu_b);

    // Clock and reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Driver: present a command and hold it until the accepting edge.
    task automatic push_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid || state != IDLE) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(n < 2000), 1);
    endtask

    task automatic check_got(input string tag, input int idx, input logic [1:0] tg,
                             input logic [2:0] op, input logic [3:0] res);
        logic [9:0] e;
        e = {tg, op, res, res == 4'd0};
        if (idx < got_q.size()) check(tag, 32'(got_q[idx]), 32'(e));
        else check(tag, 32'hDEAD, 32'(e));
    endtask

    // Monitor and scoreboard, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        logic [9:0] obs;
        logic [3:0] r;
        if (!rst_n) begin
            exp_q.delete();
            model_tag  = 0;
            held_valid = 1'b0;
        end else begin
            obs = {out_tag, out_op, out_result, out_zero};
            if (out_valid) begin
                if (held_valid) check("hold_stable", 32'(obs), 32'(held));
                held       = obs;
                held_valid = !out_ready;
            end else begin
                held_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(obs);
                if (exp_q.size() == 0) check("out_without_cmd", 32'(exp_q.size()), 1);
                else check("scoreboard", 32'(obs), 32'(exp_q.pop_front()));
                if (stream_mode && last_out_cyc >= 0) check("stream_period", cyc - last_out_cyc, 3);
                last_out_cyc = cyc;
            end
            if (stream_mode) check("stream_in_ready", 32'(in_ready), 1);
            if (in_valid && in_ready) begin
                r = ref_alu(in_op, in_a, in_b);
                exp_q.push_back({2'(model_tag), in_op, r, r == 4'd0});
                model_tag = (model_tag + 1) % 4;
            end
        end
    end

    initial begin
        int n;

        do_reset();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_b", 32'(alu_b), 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_result", 32'(out_result), 0);
        check("rst_out_zero", 32'(out_zero), 0);
        check("rst_out_op", 32'(out_op), 0);
        check("rst_out_tag", 32'(out_tag), 0);
        check("rst_state", 32'(state), 32'(IDLE));

        // Single add and its latency
        out_ready = 1'b1;
        push_cmd(OP_ADD, 4'd3, 4'd5);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("add_latency", n, 3);
        check("add_result", 32'(out_result), 8);
        check("add_zero", 32'(out_zero), 0);
        check("add_tag", 32'(out_tag), 0);
        wait_drain();

        // Op sweep on a=3, b=5, then a multiply that wraps
        do_reset();
        got_q.delete();
        for (int i = 0; i < 8; i++) push_cmd(3'(i), 4'd3, 4'd5);
        push_cmd(OP_MUL, 4'd7, 4'd3);
        wait_drain();
        check("sweep_count", got_q.size(), 9);
        for (int i = 0; i < 8; i++) check_got("sweep", i, 2'(i % 4), 3'(i), 4'(sweep_res[i]));
        check_got("mul_wrap", 8, 2'd0, OP_MUL, 4'd5);

        // Zero flag
        got_q.delete();
        push_cmd(OP_SUB, 4'd6, 4'd6);
        push_cmd(OP_XOR, 4'd9, 4'd9);
        wait_drain();
        check_got("zero_sub", 0, 2'd1, OP_SUB, 4'd0);
        check_got("zero_xor", 1, 2'd2, OP_XOR, 4'd0);
        if (got_q.size() > 1) check("zero_flag", 32'(got_q[1][0]), 1);

        // Backpressure: 4 buffered plus 1 issued fills the front end
        do_reset();
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(OP_ADD, 4'(i), 4'd1);
            if (i == 3) check("bp_ready_before_full", 32'(in_ready), 1);
        end
        check("bp_ready_full", 32'(in_ready), 0);
        fork
            push_cmd(OP_ADD, 4'd5, 4'd1);
            begin
                repeat (10) @(negedge clk);
                check("bp_ready_blocked", 32'(in_ready), 0);
                check("bp_out_valid", 32'(out_valid), 1);
                check("bp_held_result", 32'(out_result), 1);
                check("bp_no_output", got_q.size(), 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) check_got("bp_order", i, 2'(i % 4), OP_ADD, 4'(i + 1));

        // Reset in the middle of SETTLE
        do_reset();
        got_q.delete();
        push_cmd(OP_ADD, 4'd1, 4'd2);
        push_cmd(OP_ADD, 4'd3, 4'd4);
        push_cmd(OP_ADD, 4'd5, 4'd6);
        check("mid_state_settle", 32'(state), 32'(SETTLE));
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", 32'(out_valid), 0);
        check("mid_in_ready", 32'(in_ready), 1);
        check("mid_alu_a", 32'(alu_a), 0);
        check("mid_alu_b", 32'(alu_b), 0);
        check("mid_alu_op", 32'(alu_op), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("mid_no_stale", got_q.size(), 0);
        check("mid_idle_valid", 32'(out_valid), 0);
        push_cmd(OP_ADD, 4'd2, 4'd2);
        wait_drain();
        check_got("mid_tag_restart", 0, 2'd0, OP_ADD, 4'd4);

        // Streaming at the sustainable rate of one command every 3 cycles
        stream_mode  = 1'b1;
        last_out_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            push_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            repeat (2) @(posedge clk);
            #1;
        end
        wait_drain();
        stream_mode = 1'b0;

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    push_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                             4'($urandom_range(0, 15)));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
